// File: rtl/sodor_stim_pkg.sv
// Shared constants, FSM state type and LFSR step for the RV32I stimulus generator.
package sodor_stim_pkg;

    localparam logic [6:0]  OP_IMM     = 7'b0010011;
    localparam logic [6:0]  OP_LOAD    = 7'b0000011;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;
    localparam logic [31:0] LFSR_TAPS  = 32'h80200003;
    localparam logic [31:0] LFSR_RESET = 32'h00000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    // One Galois right-shift step of the 32-bit LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR with seed load (zero seed forced to 1) and step enable.
module stim_lfsr32
    import sodor_stim_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        step_i,
    output logic [31:0] next_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next state: load wins over step; an all-zero seed would lock the LFSR, so use 1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? LFSR_RESET : seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers sample pre-edge values.
        if (!reset_n) begin
            state_q <= LFSR_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // The instruction is always built from the post-step value.
    assign next_o = lfsr_next(state_q);

endmodule

// File: rtl/instr_stim_gen.sv
// Random RV32I ALU-immediate / load instruction generator with valid/ready output.
module instr_stim_gen
    import sodor_stim_pkg::*;
#(
    parameter logic [4:0]  REG_MASK      = 5'h1F,
    parameter int unsigned ALU_WEIGHT    = 4,
    parameter logic [2:0]  LOAD_F3_MASK  = 3'b100,
    parameter logic [11:0] LOAD_IMM_MASK = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_seed,
    input  logic [15:0] cfg_count,
    input  logic        cfg_alu_en,
    input  logic        cfg_load_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        busy,
    output logic        done,
    output logic [15:0] emitted
);

    localparam logic [3:0] ALU_W = 4'(ALU_WEIGHT);

    state_e      state_q,   state_d;
    logic [15:0] count_q,   count_d;
    logic        alu_en_q,  alu_en_d;
    logic        load_en_q, load_en_d;
    logic        valid_q,   valid_d;
    logic [31:0] instr_q,   instr_d;
    logic [15:0] emitted_q, emitted_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

    logic        lfsr_load;
    logic        lfsr_step;
    logic [31:0] lfsr_post;

    logic [11:0] imm;
    logic [11:0] alu_imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  sel;
    logic        use_alu;
    logic [31:0] gen_instr;

    logic        xfer;
    logic [15:0] emitted_inc;
    logic        last_xfer;

    stim_lfsr32 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (lfsr_load),
        .seed_i  (cfg_seed),
        .step_i  (lfsr_step),
        .next_o  (lfsr_post)
    );

    // Field extraction, class choice and legalisation of the candidate instruction.
    always_comb begin
        imm     = lfsr_post[11:0];
        rs1     = lfsr_post[16:12] & REG_MASK;
        rd      = lfsr_post[21:17] & REG_MASK;
        f3      = lfsr_post[24:22];
        sel     = lfsr_post[27:25];
        alu_imm = imm;
        // Weighted choice only when both classes are on; otherwise the enabled one.
        use_alu = alu_en_q && (!load_en_q || ({1'b0, sel} < ALU_W));
        gen_instr = NOP_INSTR;
        if (use_alu) begin
            // Shifts keep only a legal shamt (plus the SRAI bit for f3=5).
            if (f3 == 3'd1) begin
                alu_imm = imm & 12'h01F;
            end else if (f3 == 3'd5) begin
                alu_imm = imm & 12'h41F;
            end
            gen_instr = {alu_imm, rs1, f3, rd, OP_IMM};
        end else if (load_en_q) begin
            gen_instr = {imm & LOAD_IMM_MASK, rs1, f3 & LOAD_F3_MASK, rd, OP_LOAD};
        end
    end

    assign xfer        = valid_q && out_ready;
    assign emitted_inc = (emitted_q == 16'hFFFF) ? emitted_q : emitted_q + 16'd1;
    assign last_xfer   = (count_q != 16'd0) && (emitted_inc == count_q);

    // FSM next state and registered-output next values; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        alu_en_d  = alu_en_q;
        load_en_d = load_en_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        emitted_d = emitted_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_LOAD;
                        lfsr_load = 1'b1;
                        emitted_d = 16'd0;
                        count_d   = cfg_count;
                        alu_en_d  = cfg_alu_en;
                        load_en_d = cfg_load_en;
                    end
                end
                ST_LOAD: begin
                    state_d   = ST_RUN;
                    lfsr_step = 1'b1;
                    valid_d   = 1'b1;
                    instr_d   = gen_instr;
                end
                ST_RUN: begin
                    if (xfer) begin
                        lfsr_step = 1'b1;
                        emitted_d = emitted_inc;
                        if (last_xfer) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            instr_d = NOP_INSTR;
                        end else begin
                            instr_d = gen_instr;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 16'd0;
            alu_en_q  <= 1'b0;
            load_en_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            emitted_q <= 16'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            alu_en_q  <= alu_en_d;
            load_en_q <= load_en_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            emitted_q <= emitted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign emitted   = emitted_q;

endmodule

// File: tb/tb_instr_stim_gen.sv
// Self-checking bench: randomized runs compared each cycle against a transaction-level model.
module tb_instr_stim_gen;

    localparam int unsigned TB_REG_MASK      = 'h1F;
    localparam int unsigned TB_ALU_WEIGHT    = 4;
    localparam int unsigned TB_LOAD_F3_MASK  = 'h4;
    localparam int unsigned TB_LOAD_IMM_MASK = 'hFFF;
    localparam logic [31:0] NOP              = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] cfg_seed;
    logic [15:0] cfg_count;
    logic        cfg_alu_en;
    logic        cfg_load_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        busy;
    logic        done;
    logic [15:0] emitted;

    int n_cmp = 0;
    int n_err = 0;
    int prop_mode = 0;  // 1: load-only properties, 2: ALU-only properties

    typedef enum {M_IDLE, M_ACT, M_DONE} mmode_e;
    mmode_e      m_mode = M_IDLE;
    int          m_lat = 0;
    logic [15:0] m_xfers = 16'd0;
    logic [15:0] m_count = 16'd0;
    logic [31:0] m_lfsr = 32'd1;
    logic        m_alu = 1'b0;
    logic        m_ld = 1'b0;

    instr_stim_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .cfg_seed    (cfg_seed),
        .cfg_count   (cfg_count),
        .cfg_alu_en  (cfg_alu_en),
        .cfg_load_en (cfg_load_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .busy        (busy),
        .done        (done),
        .emitted     (emitted)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Instruction the spec's rules give for post-step LFSR value s.
    function automatic logic [31:0] model_enc(input logic [31:0] s, input logic alu, input logic ld);
        int unsigned imm, rs1, rd, f3, sel;
        imm = s % 4096;
        rs1 = ((s / 4096) % 32) & TB_REG_MASK;
        rd  = ((s / 131072) % 32) & TB_REG_MASK;
        f3  = (s / 4194304) % 8;
        sel = (s / 33554432) % 8;
        if (!alu && !ld) return NOP;
        if (alu && (!ld || sel < TB_ALU_WEIGHT)) begin
            if (f3 == 1) imm = imm % 32;
            else if (f3 == 5) imm = imm & 'h41F;
            return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end
        return ((imm & TB_LOAD_IMM_MASK) << 20) | (rs1 << 15) |
               ((f3 & TB_LOAD_F3_MASK) << 12) | (rd << 7) | 'h03;
    endfunction

    // Compare process: advance model for the edge just taken, check outputs, then consume inputs.
    initial begin
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [6:0]  hi;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_mode  = M_IDLE;
                m_lat   = 0;
                m_xfers = 16'd0;
            end else if (m_mode == M_ACT && m_lat > 0) begin
                m_lat--;
            end
            exp_valid = (m_mode == M_ACT) && (m_lat == 0);
            exp_instr = exp_valid ? model_enc(m_lfsr, m_alu, m_ld) : NOP;
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("out_instr", out_instr, exp_instr);
            check("busy", 32'(busy), 32'(exp_valid));
            check("done", 32'(done), 32'(m_mode == M_DONE));
            check("emitted", 32'(emitted), 32'(m_xfers));
            if (out_valid && prop_mode == 1) begin
                check("load_opcode", 32'(out_instr[6:0]), 32'h03);
                check("load_f3", 32'(out_instr[14:12] == 3'd0 || out_instr[14:12] == 3'd4), 32'd1);
                check("load_imm_mask", 32'(out_instr[31:20]) & ~TB_LOAD_IMM_MASK, 32'd0);
            end
            if (out_valid && prop_mode == 2) begin
                hi = out_instr[31:25];
                check("alu_opcode", 32'(out_instr[6:0]), 32'h13);
                if (out_instr[14:12] == 3'd1) check("slli_hi", 32'(hi), 32'd0);
                if (out_instr[14:12] == 3'd5) check("srxi_hi", 32'(hi == 7'd0 || hi == 7'h20), 32'd1);
            end
            if (reset_n) begin
                if (abort) begin
                    m_mode = M_IDLE;
                    m_lat  = 0;
                end else if (m_mode != M_ACT) begin
                    if (start) begin
                        m_mode  = M_ACT;
                        m_lat   = 2;
                        m_xfers = 16'd0;
                        m_count = cfg_count;
                        m_alu   = cfg_alu_en;
                        m_ld    = cfg_load_en;
                        m_lfsr  = model_step((cfg_seed == 32'd0) ? 32'd1 : cfg_seed);
                    end
                end else if (exp_valid && out_ready) begin
                    m_xfers = (m_xfers == 16'hFFFF) ? m_xfers : m_xfers + 16'd1;
                    m_lfsr  = model_step(m_lfsr);
                    if (m_count != 16'd0 && m_xfers == m_count) m_mode = M_DONE;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] seed, input logic [15:0] cnt,
                            input logic alu, input logic ld);
        cfg_seed    = seed;
        cfg_count   = cnt;
        cfg_alu_en  = alu;
        cfg_load_en = ld;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int ready_pct);
        int n = 0;
        while (!done && n < budget) begin
            out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            tick();
            n++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [15:0] exp_em;
        reset_n = 1'b0;
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cfg_seed = 32'd0; cfg_count = 16'd0; cfg_alu_en = 1'b0; cfg_load_en = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, NOP);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_emitted", 32'(emitted), 32'd0);
        reset_n = 1'b1;
        tick();

        // Pin the model on the hand-computed first word of seed 1.
        check("model_pin", model_enc(model_step(32'd1), 1'b1, 1'b0), 32'h00300813);

        // Seed 1, one ALU instruction, consumer always ready.
        out_ready = 1'b1;
        do_start(32'd1, 16'd1, 1'b1, 1'b0);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_instr", out_instr, 32'h00300813);
        tick();
        check("single_done", 32'(done), 32'd1);
        check("single_emitted", 32'(emitted), 32'd1);

        // Stall for 5 cycles: output must hold.
        out_ready = 1'b0;
        do_start(32'd1, 16'd4, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", out_instr, 32'h00300813);
            tick();
        end
        run_until_done(50, 100);
        check("stall_emitted", 32'(emitted), 32'd4);

        // Load-only, 200 words.
        prop_mode = 1;
        do_start($urandom, 16'd200, 1'b0, 1'b1);
        run_until_done(3000, 70);
        prop_mode = 0;
        check("load_emitted", 32'(emitted), 32'd200);

        // ALU-only, 500 words.
        prop_mode = 2;
        do_start($urandom, 16'd500, 1'b1, 1'b0);
        run_until_done(3000, 90);
        prop_mode = 0;
        check("alu_emitted", 32'(emitted), 32'd500);

        // Both classes disabled: three NOP transfers.
        do_start($urandom, 16'd3, 1'b0, 1'b0);
        tick();
        check("nop_valid", 32'(out_valid), 32'd1);
        check("nop_instr", out_instr, NOP);
        run_until_done(100, 60);
        check("nop_emitted", 32'(emitted), 32'd3);

        // Abort coinciding with a transfer: not counted.
        out_ready = 1'b1;
        do_start($urandom, 16'd0, 1'b1, 1'b1);
        repeat (8) tick();
        exp_em = m_xfers;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_emitted", 32'(emitted), 32'(exp_em));

        // Abort has priority over start.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick(); tick();
        check("abort_over_start", {30'd0, busy, out_valid}, 32'd0);

        // Start during RUN is ignored; seed 0 behaves as 1.
        do_start(32'd0, 16'd0, 1'b1, 1'b1);
        repeat (10) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
        do_start($urandom, 16'd5, 1'b0, 1'b1);
        repeat (10) begin out_ready = 1'($urandom_range(0, 1)); tick(); end
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Asynchronous reset in the middle of RUN.
        out_ready = 1'b1;
        do_start($urandom, 16'd0, 1'b1, 1'b1);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_instr", out_instr, NOP);
        check("arst_busy_done", {30'd0, busy, done}, 32'd0);
        check("arst_emitted", 32'(emitted), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Randomized runs.
        for (int i = 0; i < 8; i++) begin
            do_start($urandom, 16'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            run_until_done(600, int'($urandom_range(30, 100)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
